// File: rtl/scalar_divide.sv
// scalar_divide: divides every complex element of a matrix beat by the constant SCALAR.
// Each component is truncated toward zero. A single-entry output register sits between
// the two AXI-Stream interfaces, so a result appears one cycle after its beat is accepted.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        synchronous active-low reset
//   s_axis_tdata   input matrix, element e = row*MAT_WIDTH+col at [e*ELEMENT_SIZE +: ELEMENT_SIZE]
//                  (real = low half, imag = high half, both two's complement)
//   s_axis_tvalid  input beat valid
//   s_axis_tready  block can accept a beat (combinational from the output register state)
//   s_axis_tlast   sideband carried with the beat
//   s_axis_tuser   sideband carried with the beat
//   m_axis_tdata   quotient matrix, same layout as the input
//   m_axis_tvalid  result valid
//   m_axis_tready  downstream accepts the result
//   m_axis_tlast   registered copy of s_axis_tlast
//   m_axis_tuser   registered copy of s_axis_tuser
module scalar_divide #(
  parameter int unsigned MAT_WIDTH    = 4,
  parameter int unsigned MAT_HEIGHT   = 4,
  parameter int unsigned ELEMENT_SIZE = 32,
  parameter int unsigned SCALAR       = 256
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic [MAT_WIDTH*MAT_HEIGHT*ELEMENT_SIZE-1:0] s_axis_tdata,
  input  logic                                        s_axis_tvalid,
  output logic                                        s_axis_tready,
  input  logic                                        s_axis_tlast,
  input  logic                                        s_axis_tuser,
  output logic [MAT_WIDTH*MAT_HEIGHT*ELEMENT_SIZE-1:0] m_axis_tdata,
  output logic                                        m_axis_tvalid,
  input  logic                                        m_axis_tready,
  output logic                                        m_axis_tlast,
  output logic                                        m_axis_tuser
);

  localparam int unsigned H        = ELEMENT_SIZE / 2;
  localparam int unsigned NUM_ELEM = MAT_WIDTH * MAT_HEIGHT;
  localparam int unsigned N        = NUM_ELEM * ELEMENT_SIZE;
  localparam bit          IS_POW2  = ((SCALAR & (SCALAR - 1)) == 0);
  localparam int unsigned SHIFT    = $clog2(SCALAR);

  // Parameter legality: even element width, and a divisor that fits as a positive H-bit value.
  if ((ELEMENT_SIZE % 2) != 0 || ELEMENT_SIZE < 4) begin : g_bad_element_size
    $error("scalar_divide: ELEMENT_SIZE must be even and at least 4");
  end
  if (SCALAR < 1 || 64'(SCALAR) > ((64'(1) << (H - 1)) - 64'(1))) begin : g_bad_scalar
    $error("scalar_divide: SCALAR must satisfy 1 <= SCALAR <= 2^(H-1)-1");
  end

  logic [N-1:0] quot;
  logic         accept;

  // Per-component truncating divider, purely combinational ahead of the output register.
  for (genvar e = 0; e < int'(NUM_ELEM); e++) begin : g_elem
    for (genvar c = 0; c < 2; c++) begin : g_comp
      logic [H-1:0] x;
      assign x = s_axis_tdata[e*ELEMENT_SIZE + c*H +: H];

      if (IS_POW2) begin : g_shift
        // Biasing negative inputs by SCALAR-1 turns the flooring shift into truncation.
        // No overflow: a negative x plus at most 2^(H-1)-2 stays inside the H-bit range.
        logic [H-1:0] biased;
        assign biased = x + (x[H-1] ? H'(SCALAR - 1) : '0);
        assign quot[e*ELEMENT_SIZE + c*H +: H] = H'($signed(biased) >>> SHIFT);
      end else begin : g_div
        // Signed division truncates toward zero; SCALAR > 1 here so no overflow case exists.
        assign quot[e*ELEMENT_SIZE + c*H +: H] = H'($signed(x) / $signed(H'(SCALAR)));
      end
    end
  end

  // One-deep output register: a new beat fits whenever the slot is empty or being drained.
  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Output register; payload only moves on an accepted beat so it holds through stalls and idles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= quot;
      m_axis_tlast  <= s_axis_tlast;
      m_axis_tuser  <= s_axis_tuser;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scalar_divide.sv
// tb_scalar_divide: table-driven vectors plus a scoreboard for scalar_divide with SCALAR = 256.
module tb_scalar_divide;

  localparam int unsigned MAT_WIDTH    = 4;
  localparam int unsigned MAT_HEIGHT   = 4;
  localparam int unsigned ELEMENT_SIZE = 32;
  localparam int unsigned SCALAR       = 256;
  localparam int unsigned NE           = MAT_WIDTH * MAT_HEIGHT;
  localparam int unsigned N            = NE * ELEMENT_SIZE;
  localparam int          NV           = 10;

  logic         clk;
  logic         reset_n;
  logic [N-1:0] s_tdata;
  logic         s_tvalid;
  logic         s_tready;
  logic         s_tlast;
  logic         s_tuser;
  logic [N-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic         m_tuser;

  typedef struct {
    logic [N-1:0] data;
    logic         last;
    logic         user;
  } exp_t;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [15:0] exp_re;
    logic [15:0] exp_im;
  } vec_t;

  exp_t sb[$];
  exp_t cur_exp;
  vec_t tbl[NV];
  int   checks = 0;
  int   errors = 0;

  scalar_divide #(
    .MAT_WIDTH   (MAT_WIDTH),
    .MAT_HEIGHT  (MAT_HEIGHT),
    .ELEMENT_SIZE(ELEMENT_SIZE),
    .SCALAR      (SCALAR)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .s_axis_tuser (s_tuser),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .m_axis_tuser (m_tuser)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [N-1:0] fill(input logic [15:0] im, input logic [15:0] re);
    logic [N-1:0] r;
    for (int e = 0; e < int'(NE); e++) r[e*ELEMENT_SIZE +: ELEMENT_SIZE] = {im, re};
    return r;
  endfunction

  // Reference: C-style integer division of each sign-extended component.
  function automatic logic [N-1:0] model(input logic [N-1:0] d);
    logic [N-1:0]       r;
    logic signed [15:0] x;
    int                 q;
    for (int e = 0; e < int'(NE); e++) begin
      for (int c = 0; c < 2; c++) begin
        x = d[e*ELEMENT_SIZE + c*16 +: 16];
        q = int'(x) / int'(SCALAR);
        r[e*ELEMENT_SIZE + c*16 +: 16] = 16'(q);
      end
    end
    return r;
  endfunction

  // Table row i: element e takes vector (i+e) mod NV, so every beat mixes signs and magnitudes.
  function automatic logic [N-1:0] tbl_in(input int i);
    logic [N-1:0] r;
    for (int e = 0; e < int'(NE); e++)
      r[e*ELEMENT_SIZE +: ELEMENT_SIZE] = {tbl[(i+e)%NV].im, tbl[(i+e)%NV].re};
    return r;
  endfunction

  function automatic logic [N-1:0] tbl_exp(input int i);
    logic [N-1:0] r;
    for (int e = 0; e < int'(NE); e++)
      r[e*ELEMENT_SIZE +: ELEMENT_SIZE] = {tbl[(i+e)%NV].exp_im, tbl[(i+e)%NV].exp_re};
    return r;
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] d, input logic [N-1:0] e, input logic l, input logic u);
    s_tdata       = d;
    s_tlast       = l;
    s_tuser       = u;
    s_tvalid      = 1'b1;
    cur_exp.data  = e;
    cur_exp.last  = l;
    cur_exp.user  = u;
  endtask

  // Returns just after the edge that accepts the current beat.
  task automatic wait_accept(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (s_tready) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: beat not accepted within 50 cycles", name);
    end
  endtask

  // Scoreboard: pop before push so an output and a new acceptance on the same edge stay ordered.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n) begin
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: unexpected output %h", m_tdata);
        end else begin
          e = sb.pop_front();
          checks++;
          if (m_tdata !== e.data || m_tlast !== e.last || m_tuser !== e.user) begin
            errors++;
            $display("FAIL scoreboard: got %h/%b/%b expected %h/%b/%b",
                     m_tdata, m_tlast, m_tuser, e.data, e.last, e.user);
          end
        end
      end
      if (s_tvalid && s_tready) sb.push_back(cur_exp);
    end
  end

  initial begin
    int           sent;
    bit           acc;
    logic [N-1:0] d;
    logic [N-1:0] a_exp;
    logic [N-1:0] b_exp;

    tbl[0] = '{16'h0200, 16'h0100, 16'h0002, 16'h0001};
    tbl[1] = '{16'hFF00, 16'hFF01, 16'hFFFF, 16'h0000};
    tbl[2] = '{16'h7FFF, 16'h8000, 16'h007F, 16'hFF80};
    tbl[3] = '{16'h00FF, 16'hFEFF, 16'h0000, 16'hFFFF};
    tbl[4] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
    tbl[5] = '{16'h8001, 16'h0101, 16'hFF81, 16'h0001};
    tbl[6] = '{16'hFE00, 16'h1234, 16'hFFFE, 16'h0012};
    tbl[7] = '{16'hEDCC, 16'h0100, 16'hFFEE, 16'h0001};
    tbl[8] = '{16'hFF80, 16'h7F00, 16'h0000, 16'h007F};
    tbl[9] = '{16'h8100, 16'h00FF, 16'hFF81, 16'h0000};

    reset_n  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    m_tready = 1'b1;
    cur_exp  = '{default: '0};

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    chk1("tready_in_reset", s_tready, 1'b1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk1("reset_tvalid", m_tvalid, 1'b0);
    chk("reset_tdata", m_tdata, '0);
    chk1("reset_tlast", m_tlast, 1'b0);
    chk1("reset_tuser", m_tuser, 1'b0);
    chk1("reset_tready", s_tready, 1'b1);

    // Single beat, one-cycle latency
    @(posedge clk); #1;
    drive(fill(16'h0100, 16'h0200), fill(16'h0001, 16'h0002), 1'b0, 1'b0);
    wait_accept("single");
    s_tvalid = 1'b0;
    @(negedge clk);
    chk1("single_tvalid", m_tvalid, 1'b1);
    chk("single_tdata", m_tdata, fill(16'h0001, 16'h0002));
    @(posedge clk); #1;

    // Table vectors back-to-back at full rate
    for (int i = 0; i < NV; i++) begin
      drive(tbl_in(i), tbl_exp(i), 1'(i % 2), 1'(i % 3 == 0));
      wait_accept("table");
    end
    s_tvalid = 1'b0;
    @(negedge clk);
    chk1("last_beat_tvalid", m_tvalid, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("idle_tvalid_low", m_tvalid, 1'b0);
    chk("idle_tdata_held", m_tdata, tbl_exp(NV-1));

    // Stall: result A held while beat B waits; release consumes A and loads B on one edge
    @(posedge clk); #1;
    m_tready = 1'b0;
    a_exp = tbl_exp(2);
    b_exp = tbl_exp(5);
    drive(tbl_in(2), a_exp, 1'b1, 1'b0);
    wait_accept("stall_a");
    drive(tbl_in(5), b_exp, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("stall_s_tready", s_tready, 1'b0);
      chk1("stall_tvalid", m_tvalid, 1'b1);
      chk("stall_tdata", m_tdata, a_exp);
      chk1("stall_tlast", m_tlast, 1'b1);
      chk1("stall_tuser", m_tuser, 1'b0);
      @(posedge clk); #1;
    end
    m_tready = 1'b1;
    @(negedge clk);
    chk1("release_s_tready", s_tready, 1'b1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    @(negedge clk);
    chk1("reload_tvalid", m_tvalid, 1'b1);
    chk("reload_tdata", m_tdata, b_exp);
    chk1("reload_tlast", m_tlast, 1'b0);
    chk1("reload_tuser", m_tuser, 1'b1);
    @(posedge clk); #1;

    // Random data with random backpressure, scoreboard-checked
    sent = 0;
    for (int cyc = 0; cyc < 1000 && (sent < 40 || s_tvalid); cyc++) begin
      m_tready = ($urandom_range(0, 3) != 0);
      if (!s_tvalid && sent < 40 && $urandom_range(0, 3) != 0) begin
        for (int e = 0; e < int'(NE); e++) begin
          d[e*ELEMENT_SIZE +: ELEMENT_SIZE] = $urandom();
          if ($urandom_range(0, 7) == 0) d[e*ELEMENT_SIZE +: 16] = 16'h8000;
        end
        drive(d, model(d), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        sent++;
      end
      @(negedge clk);
      acc = s_tvalid && s_tready;
      @(posedge clk); #1;
      if (acc) s_tvalid = 1'b0;
    end
    chk1("random_all_accepted", (sent == 40) && !s_tvalid, 1'b1);
    m_tready = 1'b1;
    for (int k = 0; k < 10 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk1("random_drained", sb.size() == 0, 1'b1);

    // Sideband alignment
    drive(tbl_in(7), tbl_exp(7), 1'b1, 1'b1);
    wait_accept("sideband");
    s_tvalid = 1'b0;
    @(negedge clk);
    chk1("sideband_tvalid", m_tvalid, 1'b1);
    chk1("sideband_tlast", m_tlast, 1'b1);
    chk1("sideband_tuser", m_tuser, 1'b1);
    chk("sideband_tdata", m_tdata, tbl_exp(7));
    @(posedge clk); #1;

    // Reset while a result is pending
    m_tready = 1'b0;
    drive(tbl_in(6), tbl_exp(6), 1'b1, 1'b1);
    wait_accept("reset_pending");
    s_tvalid = 1'b0;
    @(negedge clk);
    chk1("pending_tvalid", m_tvalid, 1'b1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk1("midreset_tvalid", m_tvalid, 1'b0);
    chk("midreset_tdata", m_tdata, '0);
    chk1("midreset_tlast", m_tlast, 1'b0);
    chk1("midreset_tuser", m_tuser, 1'b0);
    chk1("midreset_s_tready", s_tready, 1'b1);
    @(posedge clk); #1;
    reset_n  = 1'b1;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk1("final_tvalid_idle", m_tvalid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
